// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmitter slice.
//   tx_state_e : transmitter FSM states
//   PAR_*      : parity-mode encodings for the PARITY parameter
//   calc_div   : clocks per bit, truncated, never below 2
//   frame_len  : clocks per complete frame for a given configuration
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int calc_div(input int clk_freq, input int baud);
      int d;
      d = clk_freq / baud;
      return (d < 2) ? 2 : d;
   endfunction

   function automatic int frame_len(input int div, input int data_bits,
                                    input int parity, input int stop_bits);
      return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * div;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..DIV-1 and raises bit_tick_o for one cycle on
// the last count of every bit period; sync_i holds the count at 0 so the
// next period starts cleanly.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   sync_i     : restart request (count forced to 0, tick suppressed)
//   bit_tick_o : one-cycle pulse at the end of each DIV-cycle bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int DIV = 5208
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_i,
   output logic bit_tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: combinational next-state assigns cnt_d on every path, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (sync_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick_o = (cnt_q == LAST) && !sync_i;

endmodule

// File: rtl/uart_tx_gen.sv
// -----------------------------------------------------------------------------
// uart_tx_gen
// UART transmitter with a one-entry holding buffer. A word accepted into the
// buffer is moved to the shift register as the start bit begins, freeing the
// buffer so the next word can queue up and follow with no idle gap.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   send_data : payload, sampled on the accept cycle
//   send_ena  : request; accepted when send_ena && send_rdy
//   send_rdy  : holding buffer empty
//   idle      : FSM in IDLE and holding buffer empty
//   tx        : registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] send_data,
   input  logic                 send_ena,
   output logic                 send_rdy,
   output logic                 idle,
   output logic                 tx
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int BCW = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

   tx_state_e            state_q;
   logic [DATA_BITS-1:0] buf_q;
   logic                 buf_full_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic                 par_q;
   logic                 tx_q;

   logic                 bit_tick;
   logic                 accept;
   logic [DATA_BITS-1:0] ld_data;
   logic                 ld_par;

   // Baud timer is held in reset while idle so START always gets a full bit.
   uart_baud_gen #(
      .DIV (DIV)
   ) u_baud (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_i     (state_q == IDLE),
      .bit_tick_o (bit_tick)
   );

   assign accept = send_ena && send_rdy;

   // Word for the next frame: the buffered one if present, otherwise a word
   // arriving on the very edge STOP ends.
   assign ld_data = buf_full_q ? buf_q : send_data;
   assign ld_par  = (PARITY == PAR_ODD) ? ~(^ld_data) : (^ld_data);

   // NOTE: the holding buffer and shift register are plain flops, so they are
   // cleared on reset along with the control state; nothing here is a RAM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         if (accept) begin
            buf_q      <= send_data;
            buf_full_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (buf_full_q) begin
                  shift_q    <= buf_q;
                  par_q      <= ld_par;
                  bit_cnt_q  <= '0;
                  buf_full_q <= 1'b0;
                  tx_q       <= 1'b0;
                  state_q    <= START;
               end
            end

            START: begin
               if (bit_tick) begin
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= '0;
                  state_q   <= DATA;
               end
            end

            DATA: begin
               if (bit_tick) begin
                  if (bit_cnt_q == LAST_DATA) begin
                     bit_cnt_q <= '0;
                     if (PARITY != PAR_NONE) begin
                        tx_q    <= par_q;
                        state_q <= PAR;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end

            PAR: begin
               if (bit_tick) begin
                  tx_q      <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= STOP;
               end
            end

            STOP: begin
               if (bit_tick) begin
                  if (bit_cnt_q == LAST_STOP) begin
                     bit_cnt_q <= '0;
                     if (buf_full_q || accept) begin
                        // Back-to-back: a same-edge request bypasses the
                        // buffer, overriding the buffer write above.
                        shift_q    <= ld_data;
                        par_q      <= ld_par;
                        buf_full_q <= 1'b0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end

            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign send_rdy = !buf_full_q;
   assign idle     = (state_q == IDLE) && !buf_full_q;
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_gen
// Four transmitter configurations run side by side on one clock:
//   0: 8N1 at 50 MHz / 9600 (DIV 5208)
//   1: 8E1, DIV 4      2: 8O1, DIV 4      3: 5N2, DIV 4
// Stimulus threads push hand-computed frame bit patterns (bit j = line level
// during bit j of the frame, start bit first) and expected start cycles; one
// monitor per configuration samples tx mid-bit and compares.
// -----------------------------------------------------------------------------
module tb_uart_tx_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] rst_w;
   logic [3:0] ena;
   logic [3:0] rdy_w;
   logic [3:0] idle_w;
   logic [3:0] tx_w;
   logic [7:0] sd [3];
   logic [4:0] sd_d;

   typedef struct {
      int          k;
      logic [15:0] bits;
      int          start;
   } exp_t;

   exp_t sb[$];
   bit   skip [4];
   int   checks = 0;
   int   passes = 0;

   uart_tx_gen #(.CLK_FREQ(50_000_000), .BAUD(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst_n(rst_w[0]), .send_data(sd[0]), .send_ena(ena[0]),
      .send_rdy(rdy_w[0]), .idle(idle_w[0]), .tx(tx_w[0]));

   uart_tx_gen #(.CLK_FREQ(40), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
      .clk(clk), .rst_n(rst_w[1]), .send_data(sd[1]), .send_ena(ena[1]),
      .send_rdy(rdy_w[1]), .idle(idle_w[1]), .tx(tx_w[1]));

   uart_tx_gen #(.CLK_FREQ(40), .BAUD(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
      .clk(clk), .rst_n(rst_w[2]), .send_data(sd[2]), .send_ena(ena[2]),
      .send_rdy(rdy_w[2]), .idle(idle_w[2]), .tx(tx_w[2]));

   uart_tx_gen #(.CLK_FREQ(40), .BAUD(10), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_d (
      .clk(clk), .rst_n(rst_w[3]), .send_data(sd_d), .send_ena(ena[3]),
      .send_rdy(rdy_w[3]), .idle(idle_w[3]), .tx(tx_w[3]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic set_data(input int k, input logic [7:0] d);
      if (k == 3) sd_d = d[4:0];
      else sd[k] = d;
   endtask

   // Called at a negedge; request is accepted on the following edge (acc).
   task automatic send(input int k, input logic [7:0] d, output int acc);
      set_data(k, d);
      ena[k] = 1'b1;
      @(negedge clk);
      acc = cyc;
      ena[k] = 1'b0;
   endtask

   task automatic push(input int k, input logic [15:0] bits, input int start);
      exp_t e;
      e.k = k; e.bits = bits; e.start = start;
      sb.push_back(e);
   endtask

   task automatic mon(input int k, input int div, input int len);
      forever begin
         @(negedge clk);
         if (rst_w[k] && tx_w[k] === 1'b0) begin
            int s, idx, n;
            logic [15:0] got;
            s = cyc;
            if (skip[k]) begin
               skip[k] = 1'b0;
               n = 0;
               while (rst_w[k] && n < 1000) begin
                  @(negedge clk);
                  n++;
               end
               continue;
            end
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].k == k) idx = i;
            if (idx < 0) begin
               checks++;
               $display("FAIL unexpected_frame%0d: start at cycle %0d, none queued", k, s);
               wait_until(s + len * div - 1);
            end else begin
               exp_t e;
               e = sb[idx];
               sb.delete(idx);
               if (e.start >= 0) check($sformatf("start%0d", k), s, e.start);
               got = '0;
               for (int j = 0; j < len; j++) begin
                  wait_until(s + j * div + div / 2);
                  got[j] = tx_w[k];
               end
               check($sformatf("frame%0d", k), got, e.bits);
            end
         end
      end
   endtask

   task automatic test_a();
      int acc, s;
      send(0, 8'h55, acc);
      s = acc + 1;
      push(0, 16'h02AA, s);
      wait_until(s + 52079);
      check("a_idle_last_stop_cycle", idle_w[0], 1'b0);
      @(negedge clk);
      check("a_idle_after_frame", idle_w[0], 1'b1);
   endtask

   task automatic test_b();
      int acc, s, s1;
      bit bad;
      // 0xA5 even parity -> parity bit 0
      send(1, 8'hA5, acc);
      s = acc + 1;
      push(1, 16'h054A, s);
      check("b_rdy_drop", rdy_w[1], 1'b0);
      @(negedge clk);
      check("b_rdy_free_in_start", rdy_w[1], 1'b1);
      check("b_tx_latency", tx_w[1], 1'b0);
      wait_until(s + 43);
      check("b_idle_last_stop_cycle", idle_w[1], 1'b0);
      @(negedge clk);
      check("b_idle_after_frame", idle_w[1], 1'b1);

      // 0x12 then 0x34 queued during DATA; 0x77 offered while full is dropped
      send(1, 8'h12, acc);
      s1 = acc + 1;
      push(1, 16'h0424, s1);
      push(1, 16'h0668, s1 + 44);
      bad = 1'b0;
      while (cyc < s1 + 88) begin
         if (cyc == s1 + 8) begin
            sd[1] = 8'h34; ena[1] = 1'b1;
         end else if (cyc == s1 + 9) begin
            ena[1] = 1'b0;
            check("b_rdy_full", rdy_w[1], 1'b0);
         end else if (cyc == s1 + 12) begin
            sd[1] = 8'h77; ena[1] = 1'b1;
         end else if (cyc == s1 + 16) begin
            ena[1] = 1'b0;
         end
         if (cyc >= s1 && idle_w[1]) bad = 1'b1;
         @(negedge clk);
      end
      check("b_idle_low_b2b", bad, 1'b0);
      check("b_idle_after_b2b", idle_w[1], 1'b1);

      // Reset mid-frame with a word pending in the buffer
      skip[1] = 1'b1;
      send(1, 8'hFF, acc);
      s = acc + 1;
      wait_until(s + 4);
      sd[1] = 8'h3C; ena[1] = 1'b1;
      @(negedge clk);
      ena[1] = 1'b0;
      wait_until(s + 20);
      rst_w[1] = 1'b0;
      @(negedge clk);
      check("b_abort_state", {tx_w[1], rdy_w[1], idle_w[1]}, 3'b111);
      rst_w[1] = 1'b1;
      repeat (60) @(negedge clk);
      check("b_pending_discarded", {tx_w[1], idle_w[1]}, 2'b11);

      // Clean frame after reset: 0xC3, parity 0
      send(1, 8'hC3, acc);
      s = acc + 1;
      push(1, 16'h0586, s);
      wait_until(s + 44);
      check("b_idle_after_clean", idle_w[1], 1'b1);
   endtask

   task automatic test_c();
      int acc, s;
      // 0xA5 odd parity -> parity bit 1
      send(2, 8'hA5, acc);
      s = acc + 1;
      push(2, 16'h074A, s);
      // 0x0F accepted on the edge STOP ends: starts with no gap
      push(2, 16'h061E, s + 44);
      wait_until(s + 43);
      check("c_idle_last_stop_cycle", idle_w[2], 1'b0);
      sd[2] = 8'h0F; ena[2] = 1'b1;
      @(negedge clk);
      ena[2] = 1'b0;
      check("c_idle_no_gap", idle_w[2], 1'b0);
      check("c_tx_no_gap", tx_w[2], 1'b0);
      wait_until(s + 88);
      check("c_idle_after_pair", idle_w[2], 1'b1);
   endtask

   task automatic test_d();
      int acc, s;
      send(3, 8'h1F, acc);
      s = acc + 1;
      push(3, 16'h00FE, s);
      wait_until(s + 31);
      check("d_idle_last_stop_cycle", idle_w[3], 1'b0);
      @(negedge clk);
      check("d_idle_after_frame", idle_w[3], 1'b1);
   endtask

   initial begin
      rst_w = '0;
      ena   = '0;
      foreach (sd[i]) sd[i] = '0;
      sd_d = '0;
      foreach (skip[i]) skip[i] = 1'b0;
      // Request held during reset must be ignored
      sd[1]  = 8'hE7;
      ena[1] = 1'b1;
      repeat (3) @(negedge clk);
      check("b_rdy_during_reset", rdy_w[1], 1'b1);
      for (int k = 0; k < 4; k++)
         check($sformatf("reset_state%0d", k), {tx_w[k], rdy_w[k], idle_w[k]}, 3'b111);
      rst_w  = '1;
      ena[1] = 1'b0;
      fork
         mon(0, 5208, 10);
         mon(1, 4, 11);
         mon(2, 4, 11);
         mon(3, 4, 8);
      join_none
      repeat (4) @(negedge clk);
      check("b_idle_after_reset_req", {tx_w[1], idle_w[1]}, 2'b11);
      fork
         test_a();
         test_b();
         test_c();
         test_d();
      join
      repeat (100) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, is the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, is the line rate in bit/s; DIV = CLK_FREQ/BAUD, integer-truncated, minimum 2.
REQ-003 Parameter DATA_BITS, default 8, sets the payload width; legal range 5..9.
REQ-004 Parameter PARITY, default 0, selects the parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, sets the number of stop bits; legal values 1 or 2.
REQ-006 clk  input  1  system clock; all logic on the rising edge; single clock domain.
REQ-007 rst_n  input  1  reset; synchronous and active-low.
REQ-008 send_data  input  DATA_BITS  payload; sampled only on the accept cycle.
REQ-009 send_ena  input  1  request valid; a transfer is accepted on any edge where send_ena=1 and send_rdy=1.
REQ-010 send_rdy  output  1  holding buffer empty; able to accept a request.
REQ-011 idle  output  1  high when the FSM is in IDLE and the holding buffer is empty.
REQ-012 tx  output  1  serial line; registered; idles high.

Function
REQ-013 The block SHALL contain a one-entry holding buffer; an accepted word is written to it and send_rdy SHALL drop on the next edge.
REQ-014 send_ena while send_rdy=0 SHALL be ignored, with no effect on state or data.
REQ-015 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-016 IDLE -> START SHALL occur on the edge after the buffer becomes full; tx=0 SHALL appear on that same edge.
REQ-017 Latency: request accepted at edge N in IDLE -> tx falls at edge N+1.
REQ-018 Each bit SHALL last exactly DIV clk cycles, counted by a baud counter that reloads at every bit boundary.
REQ-019 The buffer SHALL be moved to the shift register on the START entry and freed at that moment, so send_rdy rises during START.
REQ-020 DATA SHALL transmit DATA_BITS bits, LSB first, using a bit counter that counts 0..DATA_BITS-1.
REQ-021 PAR SHALL be entered only if PARITY!=0; even parity bit = XOR of the data bits; odd parity bit = its inverse.
REQ-022 STOP SHALL drive tx=1 for STOP_BITS*DIV cycles.
REQ-023 At the end of STOP, if the buffer is full the FSM SHALL go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-024 A request accepted on the same edge that STOP ends SHALL be treated as buffer full (back-to-back, no gap).
REQ-025 The frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV cycles.
REQ-026 The counter width SHALL be $clog2(DIV) bits; the counter SHALL not wrap and SHALL reload to 0 at DIV-1.

Reset
REQ-027 With rst_n=0 at an edge, the block SHALL set tx=1, state IDLE, buffer empty, send_rdy=1, idle=1, and all counters and the shift register to 0.
REQ-028 Reset mid-frame SHALL abort the frame; tx=1 from the next edge, and the pending buffered word SHALL be discarded.
REQ-029 send_ena asserted while rst_n=0 SHALL be ignored.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and a frame-length function.
REQ-031 Sub-module uart_baud_gen SHALL produce a one-cycle bit_tick every DIV cycles and restart on a sync input; the FSM consumes bit_tick.

Verification (CLK_FREQ=50e6, BAUD=9600, DIV=5208 unless stated)
REQ-032 8N1, send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 5208 cycles, frame 52080 cycles, then idle=1.
REQ-033 8E1, 0xA5 -> parity bit 0; 8O1, 0xA5 -> parity bit 1; frame 57288 cycles.
REQ-034 Send 0x12, then 0x34 during the 0x12 DATA phase -> second start bit begins at cycle 52080 exactly; idle stays 0 throughout.
REQ-035 send_ena with a new word while send_rdy=0 -> word dropped; only the two accepted words appear on tx.
REQ-036 rst_n=0 at cycle 20000 of a frame -> tx=1, idle=1, send_rdy=1 on the next edge; a new request afterwards yields a clean frame.
REQ-037 DATA_BITS=5, STOP_BITS=2, DIV=4, send 0x1F -> tx 0,1,1,1,1,1,1,1, frame 32 cycles.
